// File: rtl/fib_pkg.sv
// Shared types and default sizing for the explicit-stack Fibonacci controller.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPAND = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  localparam int DW_DEF    = 8;
  localparam int RES_W_DEF = 16;
  localparam int N_MAX_DEF = 24;

endpackage

// File: rtl/fib_stack_ctrl.sv
// Computes fib(n) by tree recursion on an external LIFO: every node >=2 is
// replaced by its two children, leaves (0/1) are popped into the accumulator.
module fib_stack_ctrl
  import fib_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int RES_W = RES_W_DEF,
  parameter int N_MAX = N_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DW-1:0]    n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [RES_W-1:0] result,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [DW-1:0]    stk_din,
  input  logic [DW-1:0]    stk_dout,
  input  logic             stk_nempty
);

  localparam logic [DW-1:0] N_LIM = DW'(N_MAX);
  localparam logic [DW-1:0] TWO   = DW'(2);
  localparam logic [DW-1:0] ONE   = DW'(1);

  state_e           state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_din  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          done_d = 1'b0;
          if (n <= N_LIM) begin
            stk_push = 1'b1;
            stk_din  = n;
            acc_d    = '0;
            err_d    = 1'b0;
            state_d  = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!stk_nempty) begin
          result_d = acc_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (stk_dout < TWO) begin
          stk_pop = 1'b1;
          acc_d   = acc_q + RES_W'(stk_dout);
        end else begin
          // Overwrite top x with x-1; EXPAND then pushes x-2 on top of it.
          stk_push = 1'b1;
          stk_pop  = 1'b1;
          stk_din  = stk_dout - ONE;
          state_d  = EXPAND;
        end
      end
      EXPAND: begin
        stk_push = 1'b1;
        stk_din  = stk_dout - ONE;
        state_d  = RUN;
      end
      DRAIN: begin
        if (stk_nempty) stk_pop = 1'b1;
        else            state_d = IDLE;
      end
      default: state_d = DRAIN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DRAIN;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule
